// File: rtl/mostrador_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
package mostrador_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] DIG_OFF   = 4'hF;

    typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-hot digit select for the given index.
    function automatic logic [3:0] dig_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction
endpackage

// File: rtl/scan_timer.sv
// Slot counter, digit index and frame-start pulse for the display scanner.
module scan_timer
    import mostrador_pkg::*;
#(
    parameter logic [15:0] DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] cnt_o,
    output digit_idx_t  idx_o,
    output logic        frame_done_o
);
    logic [15:0] cnt_q, cnt_d;
    digit_idx_t  idx_q, idx_d;
    logic        started_q, started_d;
    logic        frame_done_q, frame_done_d;
    logic        wrap;

    always_comb begin
        wrap         = (cnt_q == DIV - 16'd1);
        cnt_d        = wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d        = wrap ? idx_q + 2'd1 : idx_q;
        // The first frame after reset has no preceding frame to mark.
        started_d    = started_q | (wrap && idx_q == 2'd3);
        frame_done_d = (cnt_q == 16'd0) && (idx_q == 2'd0) && started_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 16'd0;
            idx_q        <= 2'd0;
            started_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            started_q    <= started_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign idx_o        = idx_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: rtl/mostrador_scan_ctrl.sv
// 4-digit common-anode display scanner with per-slot blank interval.
// Optional blink support is compiled in with BLINK_MOSTRADOR_EN.
module mostrador_scan_ctrl
    import mostrador_pkg::*;
#(
    parameter logic [15:0] DIV          = 16'd50000,
    parameter logic [15:0] BLANK_CYC    = 16'd500,
    parameter logic [7:0]  BLINK_FRAMES = 8'd50
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [6:0]  PAT0,
    input  logic [6:0]  PAT1,
    input  logic [6:0]  PAT2,
    input  logic [6:0]  PAT3,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  DIG_EN,
`ifdef BLINK_MOSTRADOR_EN
    input  logic        BLINK,
`endif
    output logic [6:0]  SEGs,
    output logic        SEG_P,
    output logic        SEG_D1,
    output logic        SEG_D2,
    output logic        SEG_D3,
    output logic        SEG_D4,
    output logic        FRAME_DONE,
    output scan_state_e dbg_state
);
    logic [15:0] cnt;
    digit_idx_t  idx;
    logic        frame_done;

    scan_timer #(.DIV(DIV)) u_timer (
        .clk          (CLK),
        .rst_n        (RST_N),
        .cnt_o        (cnt),
        .idx_o        (idx),
        .frame_done_o (frame_done)
    );

    scan_state_e state_q, state_d;
    logic [6:0]  pat_q, pat_d;
    logic        dp_q, dp_d;
    logic        show_q, show_d;
    logic [6:0]  segs_q, segs_d;
    logic        segp_q, segp_d;
    logic [3:0]  dig_q, dig_d;
    logic [6:0]  pat_mux;
    logic        visible;

`ifdef BLINK_MOSTRADOR_EN
    logic       phase_q, phase_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_done) begin
            if (!BLINK) begin
                phase_d     = 1'b1;
                frame_cnt_d = 8'd0;
            end else if (frame_cnt_q + 8'd1 == BLINK_FRAMES) begin
                phase_d     = ~phase_q;
                frame_cnt_d = 8'd0;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
        visible = ~BLINK | phase_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q     <= 1'b1;
            frame_cnt_q <= 8'd0;
        end else begin
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign visible = 1'b1;
`endif

    always_comb begin
        case (idx)
            2'd0:    pat_mux = PAT0;
            2'd1:    pat_mux = PAT1;
            2'd2:    pat_mux = PAT2;
            default: pat_mux = PAT3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        dp_d    = dp_q;
        show_d  = show_q;
        segs_d  = SEG_BLANK;
        segp_d  = 1'b1;
        dig_d   = DIG_OFF;
        case (state_q)
            ST_BLANK: begin
                // Inputs are sampled once per slot so a digit never tears.
                if (cnt == BLANK_CYC) begin
                    state_d = ST_DRIVE;
                    pat_d   = pat_mux;
                    dp_d    = DP_IN[idx];
                    show_d  = DIG_EN[idx] & visible;
                end
            end
            default: begin
                if (cnt == 16'd0) state_d = ST_BLANK;
            end
        endcase
        if (state_d == ST_DRIVE && show_d) begin
            segs_d = pat_d;
            segp_d = ~dp_d;
            dig_d  = dig_sel(idx);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_BLANK;
            pat_q   <= SEG_BLANK;
            dp_q    <= 1'b0;
            show_q  <= 1'b0;
            segs_q  <= SEG_BLANK;
            segp_q  <= 1'b1;
            dig_q   <= DIG_OFF;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            dp_q    <= dp_d;
            show_q  <= show_d;
            segs_q  <= segs_d;
            segp_q  <= segp_d;
            dig_q   <= dig_d;
        end
    end

    assign SEGs       = segs_q;
    assign SEG_P      = segp_q;
    assign SEG_D1     = dig_q[0];
    assign SEG_D2     = dig_q[1];
    assign SEG_D3     = dig_q[2];
    assign SEG_D4     = dig_q[3];
    assign FRAME_DONE = frame_done;
    assign dbg_state  = state_q;

    a_one_select: assert property (@(posedge CLK) disable iff (!RST_N)
        $countones(~dig_q) <= 1);
    a_params_legal: assert property (@(posedge CLK)
        (BLANK_CYC != 16'd0) && (DIV > BLANK_CYC) && (BLINK_FRAMES != 8'd0));
endmodule

// File: tb/tb_mostrador_scan_ctrl.sv
// Self-checking bench for mostrador_scan_ctrl (DIV=8, BLANK_CYC=2).
module tb_mostrador_scan_ctrl;
  import mostrador_pkg::*;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  pat [4];
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  dig_en = 4'hF;
  logic        blink = 1'b0;
  logic [6:0]  segs;
  logic        seg_p, d1, d2, d3, d4, frame_done;
  scan_state_e dbg_state;

  mostrador_scan_ctrl #(
    .DIV(16'd8), .BLANK_CYC(16'd2), .BLINK_FRAMES(8'd2)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .PAT0(pat[0]), .PAT1(pat[1]), .PAT2(pat[2]), .PAT3(pat[3]),
    .DP_IN(dp_in), .DIG_EN(dig_en),
`ifdef BLINK_MOSTRADOR_EN
    .BLINK(blink),
`endif
    .SEGs(segs), .SEG_P(seg_p),
    .SEG_D1(d1), .SEG_D2(d2), .SEG_D3(d3), .SEG_D4(d4),
    .FRAME_DONE(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit blink_mode = 1'b0;
  string cur_tag = "init";

  // observation vector: {state, sel[3:0], segs[6:0], segp, fd}
  logic [13:0] exp_q[$];
  logic [13:0] obs_log[$];
  int          fd_cycles[$];

  logic [6:0] m_pat [4];
  logic       m_dp  [4];
  logic       m_en  [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [13:0] observe();
    return {dbg_state == ST_DRIVE, d4, d3, d2, d1, segs, seg_p, frame_done};
  endfunction

  function automatic logic [13:0] model_out(input int c);
    int k, slot, f;
    logic st, vis, fd, p;
    logic [3:0] sel;
    logic [6:0] sg;
    k    = c % DIV;
    slot = (c / DIV) % 4;
    f    = c / (4 * DIV);
    st   = (k >= BLANK);
    vis  = blink_mode ? (((f / BF) % 2) == 0) : 1'b1;
    sel  = 4'hF;
    sg   = 7'h7F;
    p    = 1'b1;
    if (st && m_en[slot] && vis) begin
      sel[slot] = 1'b0;
      sg        = m_pat[slot];
      p         = ~m_dp[slot];
    end
    fd = (k == 0) && (slot == 0) && (f >= 1);
    return {st, sel, sg, p, fd};
  endfunction

  // driver: one clock cycle with scoreboard push / pop
  task automatic step();
    logic [13:0] got, e;
    int k, slot;
    k    = cyc % DIV;
    slot = (cyc / DIV) % 4;
    if (k == BLANK) begin
      m_pat[slot] = pat[slot];
      m_dp[slot]  = dp_in[slot];
      m_en[slot]  = dig_en[slot];
    end
    exp_q.push_back(model_out(cyc));
    @(posedge clk);
    #1;
    got = observe();
    e   = exp_q.pop_front();
    check_eq(cur_tag, {18'd0, got}, {18'd0, e});
    check_eq("one_select", {31'd0, $countones(got[12:9]) >= 3}, 32'd1);
    obs_log.push_back(got);
    if (got[0]) fd_cycles.push_back(cyc);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", {18'd0, observe()}, {18'd0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    exp_q.delete();
    obs_log.delete();
    fd_cycles.delete();
    for (int i = 0; i < 4; i++) begin
      m_pat[i] = 7'h7F;
      m_dp[i]  = 1'b0;
      m_en[i]  = 1'b0;
    end
  endtask

  task automatic set_basic();
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
    dig_en = 4'hF;
    dp_in  = 4'h0;
  endtask

  initial begin
    set_basic();

    cur_tag = "basic";
    do_reset();
    run(96);
    check_eq("b_c1_sel",  {28'd0, obs_log[1][12:9]},  32'hF);
    check_eq("b_c2_sel",  {28'd0, obs_log[2][12:9]},  32'b1110);
    check_eq("b_c2_seg",  {25'd0, obs_log[2][8:2]},   32'h40);
    check_eq("b_c7_sel",  {28'd0, obs_log[7][12:9]},  32'b1110);
    check_eq("b_c8_sel",  {28'd0, obs_log[8][12:9]},  32'hF);
    check_eq("b_c10_sel", {28'd0, obs_log[10][12:9]}, 32'b1101);
    check_eq("b_c10_seg", {25'd0, obs_log[10][8:2]},  32'h79);
    check_eq("b_c34_seg", {25'd0, obs_log[34][8:2]},  32'h40);
    check_eq("fd_count",  fd_cycles.size(), 32'd2);
    if (fd_cycles.size() == 2) begin
      check_eq("fd_first",  fd_cycles[0], 32'd32);
      check_eq("fd_second", fd_cycles[1], 32'd64);
    end

    cur_tag = "dis_dp";
    dig_en = 4'b1011;
    dp_in  = 4'b0001;
    do_reset();
    run(40);
    check_eq("dp_c2_p",   {31'd0, obs_log[2][1]},     32'd0);
    check_eq("dp_c10_p",  {31'd0, obs_log[10][1]},    32'd1);
    check_eq("dis_c20_sel", {28'd0, obs_log[20][12:9]}, 32'hF);
    check_eq("dis_c20_seg", {25'd0, obs_log[20][8:2]},  32'h7F);

    cur_tag = "mid_change";
    set_basic();
    do_reset();
    run(4);
    pat[0] = 7'h12;
    run(36);
    check_eq("mid_c7_seg",  {25'd0, obs_log[7][8:2]},  32'h40);
    check_eq("mid_c34_seg", {25'd0, obs_log[34][8:2]}, 32'h12);

    cur_tag = "reset_mid";
    pat[0] = 7'h40;
    do_reset();
    run(14);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {18'd0, observe()}, {18'd0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    do_reset();
    run(16);
    check_eq("rr_c1_sel", {28'd0, obs_log[1][12:9]}, 32'hF);
    check_eq("rr_c2_sel", {28'd0, obs_log[2][12:9]}, 32'b1110);
    check_eq("rr_c7_seg", {25'd0, obs_log[7][8:2]},  32'h40);

    cur_tag = "random";
    do_reset();
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 3) == 0) pat[$urandom_range(0, 3)] = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) dp_in  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dig_en = 4'($urandom_range(0, 15));
      step();
    end

`ifdef BLINK_MOSTRADOR_EN
    cur_tag = "blink";
    set_basic();
    blink = 1'b1;
    blink_mode = 1'b1;
    do_reset();
    run(192);
    check_eq("bl_c2_sel",   {28'd0, obs_log[2][12:9]},   32'b1110);
    check_eq("bl_c34_sel",  {28'd0, obs_log[34][12:9]},  32'b1110);
    check_eq("bl_c66_sel",  {28'd0, obs_log[66][12:9]},  32'hF);
    check_eq("bl_c98_sel",  {28'd0, obs_log[98][12:9]},  32'hF);
    check_eq("bl_c130_sel", {28'd0, obs_log[130][12:9]}, 32'b1110);
    blink = 1'b0;
    blink_mode = 1'b0;
`endif

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mostrador_scan_ctrl.md
# mostrador_scan_ctrl

Time-multiplexing scheduler for the board's 4-digit common-anode 7-segment display. It shares the single segment bus (SEGs, SEG_P) between four digit requesters, each supplying an active-low segment pattern such as the output of the irrigation-status encoder. It enables one digit select at a time with a fixed refresh schedule and an anti-ghosting blank interval. It sits between the per-digit glyph encoders and the display pins.

## Interface
Parameters:
- DIV, 16'd50000: clock cycles per digit slot; legal range DIV > BLANK_CYC.
- BLANK_CYC, 16'd500: blank cycles at the start of each slot; must be ≥ 1.
- BLINK_FRAMES, 8'd50: frames per blink half-period (BLINK_MOSTRADOR_EN only).

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- PAT0..PAT3  in  7 each  active-low segment patterns for digits 1..4; bit 0 = segment a … bit 6 = segment g.
- DP_IN  in  4  active-high decimal-point request per digit.
- DIG_EN  in  4  per-digit enable; a disabled digit keeps its slot but stays dark.
- BLINK  in  1  blink request (BLINK_MOSTRADOR_EN only).
- SEGs  out  7  active-low segment bus.
- SEG_P  out  1  active-low decimal point.
- SEG_D1..SEG_D4  out  1 each  active-low digit selects.
- FRAME_DONE  out  1  one-cycle pulse at each frame start after the first.

## Operation
- Two-state FSM, evaluated every slot:
  - BLANK: all selects high, SEGs = 7'h7F, SEG_P = 1.
  - DRIVE: exactly one select low.
- Slot counter cnt runs 0..DIV-1 and wraps. On wrap, the digit index idx advances 0→1→2→3→0.
- BLANK → DRIVE at cnt = BLANK_CYC. At that edge, PAT[idx], DP_IN[idx] and DIG_EN[idx] are captured; no tearing within a slot.
- DRIVE → BLANK at the cnt wrap.
- If the captured DIG_EN bit is 0, DRIVE outputs equal BLANK outputs.
- All outputs are registered; no combinational path from inputs to pins.
- At most one SEG_Dx is low in any cycle. Two or more low at once is a fatal error.
- Reset (async assert, any time, including mid-slot):
  - Immediately: SEGs = 7'h7F, SEG_P = 1, SEG_D1..D4 = 1, FRAME_DONE = 0.
  - Internally: cnt = 0, idx = 0, state BLANK, blink phase on.
- Reset release restarts the schedule at cycle 0 of digit 1.

## Timing
- Cycle 0 is the first rising CLK edge after RST_N deasserts. Frame length = 4·DIV cycles.
- Digit d (0..3) is driven in frame-relative cycles d·DIV+BLANK_CYC through d·DIV+DIV-1.
- Input-to-pin latency: a pattern must be stable at the capture edge; it appears on the same cycle the select goes low.
- Input changes mid-DRIVE appear in the digit's next slot, 4·DIV cycles later.
- FRAME_DONE is high in frame-relative cycle 0 of frames 2, 3, …; never in the first frame after reset.
- Counter widths are 16 bits. No overflow is possible within the legal parameter range.

## Configuration
- BLINK_MOSTRADOR_EN defined:
  - Adds the BLINK port and a frame counter that toggles the blink phase every BLINK_FRAMES frames. The phase is updated on FRAME_DONE.
  - With BLINK = 1 and phase off, every DRIVE slot outputs BLANK values.
  - With BLINK = 0, the phase is forced to on at the next frame start.
- Undefined: no BLINK port and no frame counter; behaviour equals BLINK = 0.

## Structure
- Shared package (mostrador_pkg):
  - SEG_BLANK = 7'h7F and DIG_OFF = 4'hF constants.
  - Scan-state enum {ST_BLANK, ST_DRIVE}.
  - Digit index typedef (2 bits).
- Sub-module scan_timer: slot counter, digit index and FRAME_DONE generation.
- The top level holds the FSM, capture registers and output registers.

## Test plan
All scenarios use DIV = 8 and BLANK_CYC = 2.
- Basic scan. PAT0..3 = 7'h40, 7'h79, 7'h24, 7'h30, DIG_EN = 4'hF, DP_IN = 0 → SEG_D1 low in cycles 2–7 with SEGs = 7'h40; SEG_D2 low in cycles 10–15 with 7'h79; pattern repeats every 32 cycles; never two selects low.
- Disable and decimal point. DIG_EN = 4'b1011, DP_IN = 4'b0001 → SEG_P low only in cycles 2–7; cycles 18–23 fully dark (all selects 1, SEGs = 7'h7F).
- Mid-slot input change. Change PAT0 to 7'h12 at cycle 4 → SEGs stays 7'h40 through cycle 7; 7'h12 appears at cycle 34.
- FRAME_DONE. Run 3 frames → pulses only at cycles 32 and 64, one cycle each.
- Reset mid-operation. Assert RST_N at cycle 13 → selects all 1 and SEGs = 7'h7F asynchronously; after release, SEG_D1 low at new cycles 2–7.
- Blink (macro defined). BLINK_FRAMES = 2, BLINK = 1 → digits visible in frames 0–1, dark in frames 2–3, visible in frames 4–5.
